// File: rtl/index_regfile_pkg.sv
// ---------------------------------------------------------------------------
// index_regfile_pkg
// Shared constants for the index register file: update opcodes and the
// soft-clear state encoding.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package index_regfile_pkg;

  // Update-port opcodes
  localparam logic U_OP_INC = 1'b0;
  localparam logic U_OP_DEC = 1'b1;

  // Soft-clear sequencer states
  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } clr_state_t;

endpackage

`default_nettype wire

// File: rtl/index_step_alu.sv
// ---------------------------------------------------------------------------
// index_step_alu
// Combinational WIDTH-bit add/subtract of a constant STEP with carry/borrow
// out and zero detect of the wrapped result.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module index_step_alu
  import index_regfile_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_op,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry,
  output logic             o_zero
);

  localparam logic [WIDTH:0] c_step = (WIDTH+1)'(STEP);

  logic [WIDTH:0] w_sum;

  // One extra bit captures carry-out on increment and borrow on decrement
  always_comb begin
    w_sum = {1'b0, i_val} + c_step;
    if (i_op == U_OP_DEC) begin
      w_sum = {1'b0, i_val} - c_step;
    end
  end

  assign o_res   = w_sum[WIDTH-1:0];
  assign o_carry = w_sum[WIDTH];
  assign o_zero  = (w_sum[WIDTH-1:0] == '0);

endmodule

`default_nettype wire

// File: rtl/index_register_file.sv
// ---------------------------------------------------------------------------
// index_register_file
// Index register file: two combinational read ports, one write port, an
// in-place inc/dec update port with ZERO/CARRY flags, and a soft-clear
// sequencer that zeroes one entry per cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module index_register_file
  import index_regfile_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 16,
  parameter int STEP   = 1,
  parameter int BYPASS = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] R_ADDR_A,
  output logic [WIDTH-1:0]  R_DATA_A,
  input  logic [ADDR_W-1:0] R_ADDR_B,
  output logic [WIDTH-1:0]  R_DATA_B,
  input  logic              S,
  input  logic [ADDR_W-1:0] W_ADDR,
  input  logic [WIDTH-1:0]  W_DATA,
  input  logic              U_EN,
  input  logic [ADDR_W-1:0] U_ADDR,
  input  logic              U_OP,
  output logic              U_ZERO,
  output logic              U_CARRY,
  input  logic              CLR,
  output logic              BUSY
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  clr_state_t        r_state;
  clr_state_t        w_next_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_zero;
  logic              r_carry;

  logic              w_busy;
  logic              w_wr;
  logic              w_upd;
  logic [WIDTH-1:0]  w_alu_res;
  logic              w_alu_carry;
  logic              w_alu_zero;

  index_step_alu #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_alu (
    .i_val   (r_mem[U_ADDR]),
    .i_op    (U_OP),
    .o_res   (w_alu_res),
    .o_carry (w_alu_carry),
    .o_zero  (w_alu_zero)
  );

  // Port gating: nothing commits while clearing; a write to the same entry
  // as an update takes priority and the update (and its flags) is dropped.
  assign w_busy = (r_state == ST_CLEARING);
  assign w_wr   = S && !w_busy;
  assign w_upd  = U_EN && !w_busy && !(S && (W_ADDR == U_ADDR));

  // Clear FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Clear FSM next-state: start on CLR, finish after the last entry
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (CLR) w_next_state = ST_CLEARING;
      ST_CLEARING: if (r_clr_cnt == c_last) w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Clear counter: restarts at 0 on entry, walks every address while busy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_clr_cnt <= '0;
    end else if (w_busy) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end else if (CLR) begin
      r_clr_cnt <= '0;
    end
  end

  // Storage array: clear sequencer owns it while busy, else write/update
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_busy) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[W_ADDR] <= W_DATA;
      end
      if (w_upd) begin
        r_mem[U_ADDR] <= w_alu_res;
      end
    end
  end

  // Flags track only updates that actually commit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_upd) begin
      r_zero  <= w_alu_zero;
      r_carry <= w_alu_carry;
    end
  end

  // Write-through is only meaningful when the write will actually commit
  assign R_DATA_A = ((BYPASS != 0) && w_wr && (W_ADDR == R_ADDR_A)) ? W_DATA : r_mem[R_ADDR_A];
  assign R_DATA_B = ((BYPASS != 0) && w_wr && (W_ADDR == R_ADDR_B)) ? W_DATA : r_mem[R_ADDR_B];

  assign U_ZERO  = r_zero;
  assign U_CARRY = r_carry;
  assign BUSY    = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_index_register_file.sv
// ---------------------------------------------------------------------------
// tb_index_register_file
// Directed bench for index_register_file (BYPASS=0 instance plus a
// BYPASS=1 instance sharing the same inputs).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_index_register_file;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ra_a = '0, ra_b = '0, wa = '0, ua = '0;
  logic [3:0] wd = '0;
  logic       s = 1'b0, u_en = 1'b0, u_op = 1'b0, clr = 1'b0;
  logic [3:0] rd_a, rd_b, bp_rd_a, bp_rd_b;
  logic       u_zero, u_carry, busy;
  logic       bp_zero, bp_carry, bp_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  index_register_file #(.WIDTH(4), .DEPTH(16), .STEP(1), .BYPASS(0)) dut (
    .CLK(clk), .RST(rst),
    .R_ADDR_A(ra_a), .R_DATA_A(rd_a), .R_ADDR_B(ra_b), .R_DATA_B(rd_b),
    .S(s), .W_ADDR(wa), .W_DATA(wd),
    .U_EN(u_en), .U_ADDR(ua), .U_OP(u_op), .U_ZERO(u_zero), .U_CARRY(u_carry),
    .CLR(clr), .BUSY(busy)
  );

  index_register_file #(.WIDTH(4), .DEPTH(16), .STEP(1), .BYPASS(1)) u_byp (
    .CLK(clk), .RST(rst),
    .R_ADDR_A(ra_a), .R_DATA_A(bp_rd_a), .R_ADDR_B(ra_b), .R_DATA_B(bp_rd_b),
    .S(s), .W_ADDR(wa), .W_DATA(wd),
    .U_EN(u_en), .U_ADDR(ua), .U_OP(u_op), .U_ZERO(bp_zero), .U_CARRY(bp_carry),
    .CLR(clr), .BUSY(bp_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s = 1'b0; u_en = 1'b0; clr = 1'b0;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [3:0] d);
    s = 1'b1; wa = a; wd = d;
    tick();
    s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    ra_a = 4'd0; ra_b = 4'd9;
    #1;
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (u_zero !== 1'b0)  begin failures++; $display("FAIL reset_zero got=%b exp=0", u_zero); end
    checks++; if (u_carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", u_carry); end
    checks++; if (rd_a !== 4'h0)    begin failures++; $display("FAIL reset_rd_a got=%h exp=0", rd_a); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    ra_a = 4'd3; ra_b = 4'd4;
    s = 1'b1; wa = 4'd3; wd = 4'hA;
    #1;
    checks++; if (rd_a !== 4'h0) begin failures++; $display("FAIL write_not_same_cycle got=%h exp=0", rd_a); end
    tick();
    s = 1'b0;
    checks++; if (rd_a !== 4'hA) begin failures++; $display("FAIL write_rd_a got=%h exp=a", rd_a); end
    checks++; if (rd_b !== 4'h0) begin failures++; $display("FAIL write_rd_b got=%h exp=0", rd_b); end
  endtask

  task automatic test_update();
    write_entry(4'd5, 4'hF);
    ra_a = 4'd5;
    u_en = 1'b1; ua = 4'd5; u_op = 1'b0;
    tick();
    u_en = 1'b0;
    checks++; if (rd_a !== 4'h0)    begin failures++; $display("FAIL inc_wrap_val got=%h exp=0", rd_a); end
    checks++; if (u_zero !== 1'b1)  begin failures++; $display("FAIL inc_wrap_zero got=%b exp=1", u_zero); end
    checks++; if (u_carry !== 1'b1) begin failures++; $display("FAIL inc_wrap_carry got=%b exp=1", u_carry); end
    u_en = 1'b1; ua = 4'd5; u_op = 1'b1;
    tick();
    u_en = 1'b0;
    checks++; if (rd_a !== 4'hF)    begin failures++; $display("FAIL dec_borrow_val got=%h exp=f", rd_a); end
    checks++; if (u_zero !== 1'b0)  begin failures++; $display("FAIL dec_borrow_zero got=%b exp=0", u_zero); end
    checks++; if (u_carry !== 1'b1) begin failures++; $display("FAIL dec_borrow_carry got=%b exp=1", u_carry); end
    // Plain increment A -> B clears both flags
    ra_b = 4'd3;
    u_en = 1'b1; ua = 4'd3; u_op = 1'b0;
    tick();
    u_en = 1'b0;
    checks++; if (rd_b !== 4'hB)    begin failures++; $display("FAIL inc_plain_val got=%h exp=b", rd_b); end
    checks++; if (u_zero !== 1'b0)  begin failures++; $display("FAIL inc_plain_zero got=%b exp=0", u_zero); end
    checks++; if (u_carry !== 1'b0) begin failures++; $display("FAIL inc_plain_carry got=%b exp=0", u_carry); end
  endtask

  task automatic test_conflict();
    write_entry(4'd7, 4'hF);
    write_entry(4'd8, 4'hF);
    ra_a = 4'd7; ra_b = 4'd8;
    // Same address: write wins, an inc of F would have set both flags
    s = 1'b1; wa = 4'd7; wd = 4'h2;
    u_en = 1'b1; ua = 4'd7; u_op = 1'b0;
    tick();
    idle_inputs();
    checks++; if (rd_a !== 4'h2)    begin failures++; $display("FAIL same_addr_val got=%h exp=2", rd_a); end
    checks++; if (u_zero !== 1'b0)  begin failures++; $display("FAIL same_addr_zero got=%b exp=0", u_zero); end
    checks++; if (u_carry !== 1'b0) begin failures++; $display("FAIL same_addr_carry got=%b exp=0", u_carry); end
    // Different addresses: both commit
    s = 1'b1; wa = 4'd7; wd = 4'h6;
    u_en = 1'b1; ua = 4'd8; u_op = 1'b0;
    tick();
    idle_inputs();
    checks++; if (rd_a !== 4'h6)    begin failures++; $display("FAIL diff_addr_wr got=%h exp=6", rd_a); end
    checks++; if (rd_b !== 4'h0)    begin failures++; $display("FAIL diff_addr_upd got=%h exp=0", rd_b); end
    checks++; if (u_zero !== 1'b1)  begin failures++; $display("FAIL diff_addr_zero got=%b exp=1", u_zero); end
    checks++; if (u_carry !== 1'b1) begin failures++; $display("FAIL diff_addr_carry got=%b exp=1", u_carry); end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 16; i++) write_entry(4'(i), 4'h5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clr_busy_start got=%b exp=1", busy); end
    // First busy cycle: attempt a write and a flag-changing update (dec 5->4)
    ra_a = 4'd0; ra_b = 4'd15;
    s = 1'b1; wa = 4'd15; wd = 4'h9;
    u_en = 1'b1; ua = 4'd14; u_op = 1'b1;
    n = 1;
    tick();
    idle_inputs();
    checks++; if (rd_a !== 4'h0)    begin failures++; $display("FAIL clr_partial_e0 got=%h exp=0", rd_a); end
    checks++; if (rd_b !== 4'h5)    begin failures++; $display("FAIL clr_write_ignored got=%h exp=5", rd_b); end
    ra_a = 4'd14;
    #1;
    checks++; if (rd_a !== 4'h5)    begin failures++; $display("FAIL clr_update_ignored got=%h exp=5", rd_a); end
    checks++; if (u_zero !== 1'b1 || u_carry !== 1'b1) begin
      failures++; $display("FAIL clr_flags_held got=%b%b exp=11", u_zero, u_carry);
    end
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n !== 16) begin failures++; $display("FAIL clr_busy_cycles got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) begin
      ra_a = 4'(i);
      #1;
      checks++; if (rd_a !== 4'h0) begin failures++; $display("FAIL clr_entry_%0d got=%h exp=0", i, rd_a); end
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 16; i++) write_entry(4'(i), 4'h5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (6) tick();
    ra_a = 4'd10; ra_b = 4'd15;
    #1;
    checks++; if (rd_a !== 4'h5 || busy !== 1'b1) begin
      failures++; $display("FAIL midclr_pre got=%h/%b exp=5/1", rd_a, busy);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midclr_busy got=%b exp=0", busy); end
    checks++; if (rd_a !== 4'h0 || rd_b !== 4'h0) begin
      failures++; $display("FAIL midclr_entries got=%h/%h exp=0/0", rd_a, rd_b);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    ra_a = 4'd2; ra_b = 4'd4;
    s = 1'b1; wa = 4'd2; wd = 4'h9;
    #1;
    checks++; if (bp_rd_a !== 4'h9) begin failures++; $display("FAIL bypass_hit got=%h exp=9", bp_rd_a); end
    checks++; if (bp_rd_b !== 4'h0) begin failures++; $display("FAIL bypass_other_port got=%h exp=0", bp_rd_b); end
    checks++; if (rd_a !== 4'h0)    begin failures++; $display("FAIL nobypass_same_cycle got=%h exp=0", rd_a); end
    tick();
    s = 1'b0;
    checks++; if (rd_a !== 4'h9)    begin failures++; $display("FAIL nobypass_next_cycle got=%h exp=9", rd_a); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_update();
    test_conflict();
    test_clear();
    test_reset_mid_clear();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
